// File: rtl/corescore_uart_tx.sv
// AXI-stream byte sink that serialises each accepted byte as an 8N1 UART frame, LSB first,
// optionally following a tlast byte with an LF frame.
module corescore_uart_tx #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUD        = 57600,
  parameter bit          APPEND_LF   = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_tdata,
  input  logic       i_tlast,
  input  logic       i_tvalid,
  output logic       o_tready,
  output logic       o_uart_tx,
  output logic       o_busy
);

  localparam int unsigned DIV = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
  localparam int unsigned CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("corescore_uart_tx: clocks per bit must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_next;
  logic [7:0]    shreg, shreg_next;
  logic [2:0]    bit_idx, bit_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          lf_pending, lf_next;
  logic          tx_next, rdy_next, busy_next;

  // State, datapath and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_idx    <= '0;
      cnt        <= '0;
      lf_pending <= 1'b0;
      o_uart_tx  <= 1'b1;
      o_tready   <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      state      <= state_next;
      shreg      <= shreg_next;
      bit_idx    <= bit_next;
      cnt        <= cnt_next;
      lf_pending <= lf_next;
      o_uart_tx  <= tx_next;
      o_tready   <= rdy_next;
      o_busy     <= busy_next;
    end
  end

  // Next state; the baud counter reloads whenever a bit period begins
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    bit_next   = bit_idx;
    cnt_next   = cnt - CW'(1);
    lf_next    = lf_pending;
    unique case (state)
      IDLE: begin
        cnt_next = cnt;
        if (i_tvalid && o_tready) begin
          state_next = START;
          shreg_next = i_tdata;
          lf_next    = APPEND_LF && i_tlast;
          cnt_next   = RELOAD;
        end
      end
      START: begin
        if (cnt == '0) begin
          state_next = DATA;
          bit_next   = 3'd0;
          cnt_next   = RELOAD;
        end
      end
      DATA: begin
        if (cnt == '0) begin
          cnt_next = RELOAD;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            shreg_next = shreg >> 1;
            bit_next   = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (cnt == '0) begin
          cnt_next = RELOAD;
          // A pending LF chains straight into its start bit with no idle cycle
          if (lf_pending) begin
            state_next = START;
            shreg_next = 8'h0A;
            lf_next    = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output values for the state being entered, so they line up with it once registered
  always_comb begin
    tx_next   = 1'b1;
    rdy_next  = 1'b0;
    busy_next = 1'b1;
    unique case (state_next)
      IDLE: begin
        rdy_next  = 1'b1;
        busy_next = 1'b0;
      end
      START:   tx_next = 1'b0;
      DATA:    tx_next = shreg_next[0];
      default: tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_corescore_uart_tx.sv
// Bench for corescore_uart_tx: two instances (LF on / LF off) on a shared stream, checked every
// cycle against a frame-position model, plus directed scenarios with literal expectations.
module tb_corescore_uart_tx;

  localparam int unsigned DIV   = 10;
  localparam int unsigned FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tdata = 8'h00;
  logic       tlast = 1'b0;
  logic       tvalid = 1'b0;
  logic [1:0] rdy, tx, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int hs0[$];
  int hs1[$];

  always #5 clk = ~clk;

  corescore_uart_tx #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .APPEND_LF(1'b1)) u_dut_lf (
    .i_clk(clk), .i_rst(rst), .i_tdata(tdata), .i_tlast(tlast), .i_tvalid(tvalid),
    .o_tready(rdy[0]), .o_uart_tx(tx[0]), .o_busy(busy[0]));

  corescore_uart_tx #(.CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .APPEND_LF(1'b0)) u_dut_nolf (
    .i_clk(clk), .i_rst(rst), .i_tdata(tdata), .i_tlast(tlast), .i_tvalid(tvalid),
    .o_tready(rdy[1]), .o_uart_tx(tx[1]), .o_busy(busy[1]));

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Model: a transmission is a byte list played out as 10*DIV cycles per byte from the handshake
  bit         m_act [2];
  int         m_pos [2];
  int         m_len [2];
  logic [7:0] m_b0  [2];
  logic       m_rdy [2];

  function automatic logic m_tx(input int d);
    int f;
    int b;
    logic [7:0] by;
    if (!m_act[d]) return 1'b1;
    f  = m_pos[d] / FRAME;
    b  = (m_pos[d] % FRAME) / DIV;
    by = (f == 0) ? m_b0[d] : 8'h0A;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return by[b-1];
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_act[d] = 1'b0;
        m_pos[d] = 0;
        m_rdy[d] = 1'b0;
      end else begin
        if (m_act[d]) begin
          m_pos[d]++;
          if (m_pos[d] == m_len[d]) m_act[d] = 1'b0;
        end else if (m_rdy[d] && tvalid) begin
          m_act[d] = 1'b1;
          m_pos[d] = 0;
          m_b0[d]  = tdata;
          m_len[d] = (d == 0 && tlast) ? 2 * FRAME : FRAME;
        end
        m_rdy[d] = !m_act[d];
      end
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (!rst && tvalid) begin
      if (rdy[0]) hs0.push_back(cyc);
      if (rdy[1]) hs1.push_back(cyc);
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      check((d == 0) ? "tx_lf" : "tx_nolf", int'(tx[d]), int'(m_tx(d)));
      check((d == 0) ? "tready_lf" : "tready_nolf", int'(rdy[d]), int'(m_rdy[d]));
      check((d == 0) ? "busy_lf" : "busy_nolf", int'(busy[d]), int'(m_act[d]));
    end
  end

  task automatic send(input logic [7:0] d, input logic l, output bit ok);
    int n0;
    n0 = hs0.size();
    ok = 1'b0;
    tdata  = d;
    tlast  = l;
    tvalid = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (hs0.size() > n0) begin
        ok = 1'b1;
        break;
      end
    end
    tvalid = 1'b0;
    check("handshake", int'(ok), 1);
  endtask

  // smp[0]=start, smp[8:1]=data, smp[9]=stop, each sampled mid-bit
  task automatic rx_frame(input int d, output logic [9:0] smp);
    bit ok;
    ok  = 1'b0;
    smp = '1;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (tx[d] == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("rx_start_seen", int'(ok), 1);
    if (!ok) return;
    repeat (DIV / 2) @(negedge clk);
    smp[0] = tx[d];
    for (int b = 1; b < 10; b++) begin
      repeat (DIV) @(negedge clk);
      smp[b] = tx[d];
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(negedge clk);
      if (rdy == 2'b11 && busy == 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_reached", int'(ok), 1);
  endtask

  initial begin
    bit ok;
    logic [9:0] f1, f2, g1;
    int t0, c0, c1, n0, n1;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_tx", int'(tx), 3);
    check("reset_tready", int'(rdy), 0);
    check("reset_busy", int'(busy), 0);
    #2 rst = 1'b0;
    #1 check("tready_before_edge", int'(rdy), 0);
    @(negedge clk);
    check("tready_after_edge", int'(rdy), 3);

    // 1: single 0x55 frame
    fork
      send(8'h55, 1'b0, ok);
      rx_frame(0, f1);
    join
    check("t1_line", int'(f1), 10'h2AA);
    check("t1_byte", int'(f1[8:1]), 8'h55);
    t0 = hs0[$];
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (rdy[0]) break;
      @(negedge clk);
    end
    check("t1_tready_low_cycles", cyc - t0, 100);

    // 2: tvalid held across two bytes
    wait_idle();
    n0 = hs0.size();
    fork
      begin send(8'h41, 1'b0, ok); send(8'h42, 1'b0, ok); end
      begin rx_frame(0, f1); rx_frame(0, f2); end
    join
    check("t2_byte_a", int'(f1[8:1]), 8'h41);
    check("t2_byte_b", int'(f2[8:1]), 8'h42);
    check("t2_handshakes", hs0.size() - n0, 2);
    if (hs0.size() >= 2) check("t2_spacing", hs0[hs0.size()-1] - hs0[hs0.size()-2], 101);

    // 3/4: tlast byte, with and without the LF
    wait_idle();
    n0 = hs0.size();
    n1 = hs1.size();
    c0 = -1;
    c1 = -1;
    fork
      begin
        send(8'h4F, 1'b1, ok);
        for (int i = 0; i < 3 * FRAME && (c0 < 0 || c1 < 0); i++) begin
          @(negedge clk);
          if (!busy[0] && c0 < 0) c0 = cyc;
          if (!busy[1] && c1 < 0) c1 = cyc;
        end
      end
      begin rx_frame(0, f1); rx_frame(0, f2); end
      rx_frame(1, g1);
    join
    t0 = hs0[$];
    check("t3_byte", int'(f1[8:1]), 8'h4F);
    check("t3_lf", int'(f2[8:1]), 8'h0A);
    check("t3_lf_stop", int'(f2[9]), 1);
    check("t3_busy_cycles", c0 - t0, 200);
    check("t4_byte", int'(g1[8:1]), 8'h4F);
    check("t4_busy_cycles", c1 - t0, 100);
    wait_idle();
    check("t3_handshakes", hs0.size() - n0, 1);
    check("t4_handshakes", hs1.size() - n1, 1);

    // 5: reset 35 cycles into a frame
    send(8'h5A, 1'b0, ok);
    repeat (35) @(negedge clk);
    check("t5_line_low", int'(tx[0]), 0);
    #2 rst = 1'b1;
    #1;
    check("t5_tx_async", int'(tx[0]), 1);
    check("t5_tready_async", int'(rdy[0]), 0);
    check("t5_busy_async", int'(busy[0]), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("t5_tready_held", int'(rdy[0]), 0);
    @(negedge clk);
    check("t5_tready_one_edge", int'(rdy[0]), 1);
    fork
      send(8'h5A, 1'b0, ok);
      rx_frame(0, f1);
    join
    check("t5_after_reset", int'(f1), {1'b1, 8'h5A, 1'b0});

    // 6: data toggling while not ready
    wait_idle();
    fork
      begin
        send(8'hC3, 1'b0, ok);
        for (int i = 0; i < 95; i++) begin
          tvalid = 1'b1;
          tdata  = 8'($urandom);
          tlast  = 1'($urandom);
          @(negedge clk);
        end
        tvalid = 1'b0;
      end
      rx_frame(0, f1);
    join
    check("t6_byte", int'(f1[8:1]), 8'hC3);

    // Random stream with occasional resets
    wait_idle();
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      tvalid = ($urandom_range(0, 3) != 0);
      tdata  = 8'($urandom);
      tlast  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1499) == 0) begin
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
      end
    end
    tvalid = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
